text_banner_renderer: RTL and testbench
=======================================

// Module: text_banner_renderer
// PURPOSE
//  Parametrised scaled-text overlay for the VGA pipeline: draws a runtime-writable ASCII string
//  of up to MAX_CHARS glyphs at (X0,Y0), magnified by 2**SCALE_LOG2, with optional blinking.
//  Replaces fixed-string title/wait screens; game FSM writes the message, renderer owns pixels.
//  Sits between vga_controller (DrawX/DrawY/frame_start) and the colour mux; drives the 8x16 font ROM.
// PARAMETERS
//  MAX_CHARS     16      string buffer depth (glyph slots), >=1
//  SCALE_LOG2    2       magnification = 1<<SCALE_LOG2 (0..3)
//  X0            100     left edge of text box, pixels
//  Y0            100     top edge of text box, pixels
//  BLINK_FRAMES  30      frames per blink half-period, >=1
//  FG_RGB        12'hEEC foreground {R,G,B} 4b each
//  BG_RGB        12'h362 background {R,G,B}
// PORTS
//  clk           in  1    pixel-domain clock
//  reset         in  1    synchronous, active-high reset
//  frame_start   in  1    one-clk pulse at start of each frame (vblank)
//  DrawX         in  10   current pixel column
//  DrawY         in  10   current pixel row
//  wr_en         in  1    write glyph into pending buffer
//  wr_idx        in  $clog2(MAX_CHARS) slot index
//  wr_char       in  7    ASCII code
//  msg_len       in  $clog2(MAX_CHARS+1) visible length, sampled at frame_start
//  blink_en      in  1    1 = text blinks, 0 = steady
//  font_address  out 11   font ROM address {char,row}
//  font_data     in  8    ROM row, valid 1 clk after font_address (synchronous ROM)
//  Red/Green/Blue out 4 each  registered pixel colour
// BEHAVIOUR
//  Buffers: writes land in PENDING copy next clk; DISPLAY copy := PENDING and len := msg_len on
//   frame_start (tear-free). wr_en with frame_start same clk: write lands, commit uses old pending.
//  Reset: pending/display all 7'h20 (space), len=0, blink cnt=0, visible=1, RGB=0, pipeline valid=0.
//  Box: DrawX in [X0, X0+len*8<<S), DrawY in [Y0, Y0+16<<S); S=SCALE_LOG2. len=0 -> empty box.
//  Stage 0 (comb): ci=(DrawX-X0)>>(3+S); fx=((DrawX-X0)>>S)&7; fy=((DrawY-Y0)>>S)&15;
//   font_address={display[ci],fy[3:0]} in box, else 11'd0. Subtractions done in 11b, no wrap use.
//  Stage 1 (reg): in_box_d, fx_d delayed 1 clk to align with font_data.
//  Stage 2 (reg): RGB=FG_RGB if in_box_d & visible & font_data[7-fx_d], else BG_RGB.
//  Latency: DrawX/DrawY -> RGB = exactly 2 clk; upstream must delay hs/vs/blank by 2.
//  Blink: blink_en=1: cnt++ on frame_start; at cnt==BLINK_FRAMES-1 -> cnt=0, visible toggles.
//   blink_en=0: cnt=0, visible=1 (same clk). Toggle applies from the frame_start clk onward.
//  wr_idx >= MAX_CHARS: write ignored. msg_len > MAX_CHARS: clamp to MAX_CHARS.
//  Reset mid-frame: RGB=0 that clk, BG_RGB 2 clk after release (len=0).
//  Non-printable codes rendered as ROM contents; no filtering.
// STRUCTURE
//  Package text_render_pkg: FONT_W=8, FONT_H=16, ASCII_SPACE=7'h20, typedef rgb12_t
//   (struct of three logic[3:0]), function rgb_unpack.
//  Sub-module text_char_buffer: pending+display arrays, write port, commit-on-frame_start,
//   comb read port (ci -> char). Top keeps address math, 2-stage pipe, blink FSM.
//  Blink FSM: 2 states SHOW/HIDE driven by cnt wrap; gated to SHOW when blink_en=0.
// TESTING
//  1 reset; write "HI" idx0/1, msg_len=2, pulse frame_start; scan Y0..Y0+63 -> FG pixels match
//    ROM 'H'/'I' 4x-scaled, pixel at X0+64 is BG, RGB lag DrawX by exactly 2 clk.
//  2 after commit, write 'Z' to idx0 mid-frame -> current frame still 'H'; next frame_start -> 'Z'.
//  3 blink_en=1, BLINK_FRAMES=3: 3 frame_starts -> text hidden (all BG), 3 more -> shown;
//    drop blink_en while hidden -> shown next clk.
//  4 wr_idx=MAX_CHARS, msg_len=MAX_CHARS+3 -> no buffer change, box width MAX_CHARS*32 px.
//  5 SCALE_LOG2=0 build: single glyph at X0..X0+7, Y0..Y0+15, pixel-exact vs ROM.
//  6 assert reset mid-line -> RGB=0 during reset, BG_RGB 2 clk after release, font_address=0.

Source files
------------

// File: rtl/text_render_pkg.sv
// Shared types and constants for the scaled text overlay.
package text_render_pkg;

  localparam int FONT_W = 8;
  localparam int FONT_H = 16;
  localparam logic [6:0] ASCII_SPACE = 7'h20;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef enum logic {
    SHOW = 1'b0,
    HIDE = 1'b1
  } blink_state_t;

  // Split a packed {R,G,B} 12-bit colour into its channel struct.
  function automatic rgb12_t rgb_unpack(input logic [11:0] rgb);
    rgb12_t c;
    c.r = rgb[11:8];
    c.g = rgb[7:4];
    c.b = rgb[3:0];
    return c;
  endfunction

endpackage

// File: rtl/text_char_buffer.sv
// Double-buffered glyph store: game logic writes the pending copy at any time,
// the display copy and visible length are swapped in only at frame_start so a
// frame never shows a half-written message.
module text_char_buffer
  import text_render_pkg::*;
#(
  parameter int MAX_CHARS = 16,
  parameter int IDX_W     = 4,
  parameter int LEN_W     = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [6:0]       wr_char,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [10:0]      rd_idx,
  output logic [6:0]       rd_char,
  output logic [LEN_W-1:0] len
);

  logic [6:0] pending [MAX_CHARS];
  logic [6:0] display [MAX_CHARS];

  // Pending copy: out-of-range slot indices are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_CHARS; i++) pending[i] <= ASCII_SPACE;
    end else if (wr_en && (32'(wr_idx) < MAX_CHARS)) begin
      pending[wr_idx] <= wr_char;
    end
  end

  // Commit on frame_start; a same-clock write is not yet visible here, so the old pending copy is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_CHARS; i++) display[i] <= ASCII_SPACE;
      len <= '0;
    end else if (frame_start) begin
      for (int i = 0; i < MAX_CHARS; i++) display[i] <= pending[i];
      len <= (msg_len > LEN_W'(MAX_CHARS)) ? LEN_W'(MAX_CHARS) : msg_len;
    end
  end

  assign rd_char = (rd_idx < 11'(MAX_CHARS)) ? display[rd_idx[IDX_W-1:0]] : ASCII_SPACE;

endmodule

// File: rtl/text_banner_renderer.sv
// Scaled ASCII banner overlay: maps the beam position to a glyph/font row,
// fetches it from the synchronous font ROM and emits a registered colour two
// clocks after DrawX/DrawY, with optional frame-counted blinking.
module text_banner_renderer
  import text_render_pkg::*;
#(
  parameter int          MAX_CHARS    = 16,
  parameter int          SCALE_LOG2   = 2,
  parameter int          X0           = 100,
  parameter int          Y0           = 100,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] FG_RGB       = 12'hEEC,
  parameter logic [11:0] BG_RGB       = 12'h362,
  localparam int         IDX_W        = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1,
  localparam int         LEN_W        = $clog2(MAX_CHARS + 1),
  localparam int         CNT_W        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [6:0]       wr_char,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             blink_en,
  output logic [10:0]      font_address,
  input  logic [7:0]       font_data,
  output logic [3:0]       Red,
  output logic [3:0]       Green,
  output logic [3:0]       Blue
);

  localparam int GLYPH_SH = $clog2(FONT_W) + SCALE_LOG2;

  logic [LEN_W-1:0] len;
  logic [6:0]       rd_char;
  logic [10:0]      dx, dy, ci;
  logic [15:0]      box_w;
  logic             in_box;
  logic [2:0]       fx;
  logic [3:0]       fy;

  logic             vld_p1;
  logic             in_box_p1;
  logic [2:0]       fx_p1;
  rgb12_t           pix_p2;

  blink_state_t     blink_state;
  logic [CNT_W-1:0] blink_cnt;
  logic             visible;

  text_char_buffer #(
    .MAX_CHARS (MAX_CHARS),
    .IDX_W     (IDX_W),
    .LEN_W     (LEN_W)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_char     (wr_char),
    .msg_len     (msg_len),
    .rd_idx      (ci),
    .rd_char     (rd_char),
    .len         (len)
  );

  // Stage 0: box test and glyph/row/column decode, subtractions kept in 11 bits
  assign dx     = {1'b0, DrawX} - 11'(X0);
  assign dy     = {1'b0, DrawY} - 11'(Y0);
  assign box_w  = 16'(len) << GLYPH_SH;
  assign in_box = (DrawX >= 10'(X0)) && ({5'd0, dx} < box_w) &&
                  (DrawY >= 10'(Y0)) && (dy < 11'(FONT_H << SCALE_LOG2));
  assign ci     = dx >> GLYPH_SH;
  assign fx     = 3'(dx >> SCALE_LOG2);
  assign fy     = 4'(dy >> SCALE_LOG2);
  assign font_address = in_box ? {rd_char, fy} : 11'd0;

  // Stage 1: align box flag and column with the ROM's one-clock read latency
  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= 1'b1;
    in_box_p1 <= in_box;
    fx_p1     <= fx;
  end

  // Stage 2: pick foreground where the glyph bit is set, black until the pipe has filled
  always_ff @(posedge clk) begin
    if (reset)                                              pix_p2 <= '0;
    else if (!vld_p1)                                       pix_p2 <= '0;
    else if (in_box_p1 && visible && font_data[3'd7 - fx_p1]) pix_p2 <= rgb_unpack(FG_RGB);
    else                                                    pix_p2 <= rgb_unpack(BG_RGB);
  end

  assign Red   = pix_p2.r;
  assign Green = pix_p2.g;
  assign Blue  = pix_p2.b;

  // Blink FSM: frame counter wraps every BLINK_FRAMES and flips SHOW/HIDE; forced to SHOW when disabled
  always_ff @(posedge clk) begin
    if (reset || !blink_en) begin
      blink_cnt   <= '0;
      blink_state <= SHOW;
    end else if (frame_start) begin
      if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_state <= (blink_state == SHOW) ? HIDE : SHOW;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign visible = (blink_state == SHOW);

endmodule

// File: tb/tb_text_banner_renderer.sv
// Scoreboard bench for text_banner_renderer: a 4x build and a 1x build share
// all inputs; expected pixels are queued at drive time and popped two clocks later.
module tb_text_banner_renderer;

  localparam int          MC  = 12;
  localparam int          X0  = 100;
  localparam int          Y0  = 100;
  localparam logic [11:0] FG  = 12'hEEC;
  localparam logic [11:0] BG  = 12'h362;

  logic       clk = 1'b0;
  logic       reset, frame_start, wr_en, blink_en;
  logic [9:0] DrawX, DrawY;
  logic [3:0] wr_idx, msg_len;
  logic [6:0] wr_char;
  logic [10:0] fa, fa0;
  logic [7:0]  fd, fd0;
  logic [3:0]  r, g, b, r0, g0, b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] font_row(input logic [10:0] a);
    logic [7:0] c, rr;
    c  = {1'b0, a[10:4]};
    rr = {4'b0, a[3:0]};
    return (c * 8'd29) ^ (rr * 8'd77) ^ 8'h5A;
  endfunction

  // Synchronous font ROMs, one per instance
  always @(posedge clk) begin
    fd  <= font_row(fa);
    fd0 <= font_row(fa0);
  end

  text_banner_renderer #(.MAX_CHARS(MC), .SCALE_LOG2(2), .X0(X0), .Y0(Y0),
    .BLINK_FRAMES(3), .FG_RGB(FG), .BG_RGB(BG)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .DrawX(DrawX), .DrawY(DrawY),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_char(wr_char), .msg_len(msg_len),
    .blink_en(blink_en), .font_address(fa), .font_data(fd),
    .Red(r), .Green(g), .Blue(b));

  text_banner_renderer #(.MAX_CHARS(MC), .SCALE_LOG2(0), .X0(X0), .Y0(Y0),
    .BLINK_FRAMES(3), .FG_RGB(FG), .BG_RGB(BG)) dut0 (
    .clk(clk), .reset(reset), .frame_start(frame_start), .DrawX(DrawX), .DrawY(DrawY),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_char(wr_char), .msg_len(msg_len),
    .blink_en(blink_en), .font_address(fa0), .font_data(fd0),
    .Red(r0), .Green(g0), .Blue(b0));

  // Reference state
  logic [6:0] m_pend [MC];
  logic [6:0] m_disp [MC];
  int         m_len, m_cnt;
  bit         m_vis;

  typedef struct {
    bit          v;
    logic [11:0] e;
    logic [11:0] e0;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h at x=%0d y=%0d t=%0t", tag, obs, exp, DrawX, DrawY, $time);
    end
  endtask

  function automatic logic [11:0] model(input int x, input int y, input int sc);
    int rx, ry, ci, fx, fy;
    logic [7:0] row;
    rx = x - X0;
    ry = y - Y0;
    if (rx < 0 || ry < 0 || rx >= m_len * 8 * sc || ry >= 16 * sc) return BG;
    ci  = rx / (8 * sc);
    fx  = (rx / sc) % 8;
    fy  = (ry / sc) % 16;
    row = font_row({m_disp[ci], 4'(fy)});
    return (m_vis && row[7 - fx]) ? FG : BG;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < MC; i++) begin
      m_pend[i] = 7'h20;
      m_disp[i] = 7'h20;
    end
    m_len = 0;
    m_cnt = 0;
    m_vis = 1'b1;
  endfunction

  // One clock: inputs already set at this negedge; compare the entry from two clocks back
  task automatic cyc(input bit v, input logic [11:0] e, input logic [11:0] e0);
    exp_t it;
    it.v = v; it.e = e; it.e0 = e0;
    sb_q.push_back(it);
    @(negedge clk);
    if (sb_q.size() == 2) begin
      it = sb_q.pop_front();
      if (it.v) begin
        check("pix_x4", {r, g, b}, it.e);
        check("pix_x1", {r0, g0, b0}, it.e0);
      end
    end
  endtask

  task automatic idle();
    DrawX = 10'd0;
    DrawY = 10'd0;
    cyc(1'b0, 12'h0, 12'h0);
  endtask

  task automatic px(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    cyc(1'b1, model(x, y, 4), model(x, y, 1));
  endtask

  task automatic scan(input int y0, input int y1, input int ys, input int x0, input int x1);
    for (int y = y0; y <= y1; y += ys)
      for (int x = x0; x <= x1; x++) px(x, y);
  endtask

  task automatic wr(input int idx, input logic [6:0] ch);
    wr_en = 1'b1; wr_idx = 4'(idx); wr_char = ch;
    idle();
    wr_en = 1'b0;
    if (idx < MC) m_pend[idx] = ch;
  endtask

  // frame_start pulse, optionally with a write in the same clock
  task automatic frame(input bit we, input int idx, input logic [6:0] ch);
    frame_start = 1'b1;
    wr_en = we; wr_idx = 4'(idx); wr_char = ch;
    idle();
    frame_start = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < MC; i++) m_disp[i] = m_pend[i];
    m_len = (int'(msg_len) > MC) ? MC : int'(msg_len);
    if (we && idx < MC) m_pend[idx] = ch;
    if (blink_en) begin
      if (m_cnt == 2) begin
        m_cnt = 0;
        m_vis = !m_vis;
      end else begin
        m_cnt++;
      end
    end
    idle();
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; wr_en = 1'b0; blink_en = 1'b0;
    wr_idx = '0; wr_char = '0; msg_len = '0;
    DrawX = 10'(X0 + 2); DrawY = 10'(Y0 + 2);
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_rgb", {r, g, b}, 12'h000);
    check("rst_fa", {1'b0, fa}, 12'h000);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rel_bg", {r, g, b}, BG);
    check("rst_rel_bg0", {r0, g0, b0}, BG);

    // "HI" at 4x and 1x
    wr(0, 7'h48);
    wr(1, 7'h49);
    msg_len = 4'd2;
    frame(1'b0, 0, 7'h00);
    scan(Y0 - 1, Y0 + 64, 1, X0 - 2, X0 + 66);

    // mid-frame write stays pending until the next commit
    wr(0, 7'h5A);
    scan(Y0, Y0 + 63, 4, X0, X0 + 31);
    frame(1'b1, 1, 7'h59);
    scan(Y0, Y0 + 63, 4, X0, X0 + 63);
    frame(1'b0, 0, 7'h00);
    scan(Y0, Y0 + 63, 4, X0, X0 + 63);

    // blinking
    blink_en = 1'b1;
    m_cnt = 0;
    repeat (3) frame(1'b0, 0, 7'h00);
    scan(Y0, Y0 + 63, 8, X0 - 1, X0 + 64);
    repeat (3) frame(1'b0, 0, 7'h00);
    scan(Y0, Y0 + 63, 8, X0 - 1, X0 + 64);
    repeat (3) frame(1'b0, 0, 7'h00);
    scan(Y0 + 4, Y0 + 4, 1, X0, X0 + 63);
    blink_en = 1'b0;
    m_cnt = 0;
    m_vis = 1'b1;
    scan(Y0 + 4, Y0 + 8, 2, X0, X0 + 63);

    // out-of-range slot ignored, overlong length clamped, full-width box
    wr(MC, 7'h51);
    for (int i = 2; i < MC; i++) wr(i, 7'(8'h41 + i));
    msg_len = 4'(MC + 3);
    frame(1'b0, 0, 7'h00);
    scan(Y0 + 5, Y0 + 45, 40, X0 - 2, X0 + MC * 32 + 2);

    // 1x glyph region pixel-exact
    scan(Y0 - 1, Y0 + 16, 1, X0 - 1, X0 + 9);

    // reset in the middle of a line
    px(X0 + 3, Y0 + 2);
    reset = 1'b1;
    DrawX = 10'(X0 + 5);
    @(negedge clk);
    sb_q.delete();
    model_reset();
    check("mid_rst_rgb", {r, g, b}, 12'h000);
    check("mid_rst_rgb0", {r0, g0, b0}, 12'h000);
    check("mid_rst_fa", {1'b0, fa}, 12'h000);
    check("mid_rst_fa0", {1'b0, fa0}, 12'h000);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rel_bg", {r, g, b}, BG);
    check("mid_rel_bg0", {r0, g0, b0}, BG);
    scan(Y0 + 2, Y0 + 2, 1, X0, X0 + 40);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
